// File: rtl/rx_frame_store.sv
// rtl/rx_frame_store.sv - ping-pong receive frame buffer with commit/release handshake
// Frames land in alternating banks; a full pair of banks drops further frames and counts them.
module rx_frame_store #(
  parameter int OCT    = 8,
  parameter int ADDR_W = 10
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic              rx_data_v,
  input  logic [OCT-1:0]    rx_data,
  output logic              frame_rdy,
  output logic              frame_bank,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_irq,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OCT-1:0]    rd_data,
  input  logic              frame_release,
  output logic [15:0]       drop_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;

  wstate_t           state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [ADDR_W:0]   len_q [2];
  logic [ADDR_W:0]   len_d [2];
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [OCT-1:0]    rd_data_q, rd_data_d;
  logic              drop_inc;
  logic              mem_we;
  logic [ADDR_W:0]   mem_waddr;

  logic [OCT-1:0]    mem [2*DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    len_d[0]   = len_q[0];
    len_d[1]   = len_q[1];
    drop_cnt_d = drop_cnt_q;
    drop_inc   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = {wr_bank_q, wr_ptr_q[ADDR_W-1:0]};
    frame_irq  = 1'b0;

    // Release is applied first so a same-cycle commit into the other bank is not disturbed.
    if (frame_release && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    case (state_q)
      W_IDLE: begin
        if (rx_data_v) begin
          if (!full_q[wr_bank_q]) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_bank_q, {ADDR_W{1'b0}}};
            wr_ptr_d  = (ADDR_W + 1)'(1);
            state_d   = W_FILL;
          end else begin
            drop_inc = 1'b1;
            state_d  = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (rx_data_v) begin
          if (wr_ptr_q == DEPTH_V) begin
            drop_inc = 1'b1;
            wr_ptr_d = '0;
            state_d  = W_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end else begin
          full_d[wr_bank_q] = 1'b1;
          len_d[wr_bank_q]  = wr_ptr_q;
          frame_irq         = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_ptr_d          = '0;
          state_d           = W_IDLE;
        end
      end
      W_DROP: begin
        if (!rx_data_v) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase

    if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    rd_data_d = mem[{rd_bank_q, rd_addr}];
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q    <= W_IDLE;
      wr_ptr_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      drop_cnt_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      len_q[0]   <= len_d[0];
      len_q[1]   <= len_d[1];
      drop_cnt_q <= drop_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Frame storage carries no reset; only committed bytes are ever presented.
  always_ff @(posedge RX_CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= rx_data;
    end
  end

  assign frame_rdy  = full_q[rd_bank_q];
  assign frame_bank = rd_bank_q;
  assign frame_len  = len_q[rd_bank_q];
  assign rd_data    = rd_data_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_store.sv
// tb/tb_rx_frame_store.sv - randomized frame-level reference bench for rx_frame_store
module tb_rx_frame_store;

  localparam int DEPTH = 1024;

  logic        RX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic        rx_data_v = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        frame_rdy;
  logic        frame_bank;
  logic [10:0] frame_len;
  logic        frame_irq;
  logic [9:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        frame_release = 1'b0;
  logic [15:0] drop_cnt;

  rx_frame_store #(.OCT(8), .ADDR_W(10)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .rx_data_v(rx_data_v), .rx_data(rx_data),
    .frame_rdy(frame_rdy), .frame_bank(frame_bank), .frame_len(frame_len),
    .frame_irq(frame_irq), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_release(frame_release), .drop_cnt(drop_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  int checks = 0;
  int errors = 0;

  // Frame-level model: count of held frames, which bank the reader sees, and their contents.
  int         m_rd, m_wr, m_cnt, m_drop;
  int         m_len [2];
  logic [7:0] bank_m [2][DEPTH];

  task automatic tick();
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_cnt = 0; m_drop = 0;
    m_len[0] = 0; m_len[1] = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdy"},  32'(frame_rdy),  0);
    check({tag, "_bank"}, 32'(frame_bank), 0);
    check({tag, "_len"},  32'(frame_len),  0);
    check({tag, "_irq"},  32'(frame_irq),  0);
    check({tag, "_rd"},   32'(rd_data),    0);
    check({tag, "_drop"}, 32'(drop_cnt),   0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rdy"},  32'(frame_rdy),  32'(m_cnt > 0));
    check({tag, "_bank"}, 32'(frame_bank), 32'(m_rd));
    if (m_cnt > 0) check({tag, "_len"}, 32'(frame_len), 32'(m_len[m_rd]));
    check({tag, "_drop"}, 32'(drop_cnt),   32'(m_drop));
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_data_v = 1'b0; frame_release = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    check_reset("rst");
  endtask

  task automatic read_check(input int a);
    rd_addr = 10'(a);
    tick();
    check("rd_data", 32'(rd_data), 32'(bank_m[m_rd][a]));
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      m_rd ^= 1;
    end
    check_outputs("rel");
  endtask

  // Streams one frame; rst_at >= 0 asserts rst for two bytes starting at that index.
  task automatic send_frame(input int len, input bit incr, input bit rel_end, input int rst_at);
    logic [7:0] buf_q[$];
    bit accept, in_rst, ok;
    accept = 1'b0;
    for (int i = 0; i < len; i++) begin
      in_rst    = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
      rst       = in_rst;
      rx_data_v = 1'b1;
      rx_data   = incr ? 8'(i) : 8'($urandom);
      if (!in_rst) begin
        if (buf_q.size() == 0) accept = (m_cnt < 2);
        buf_q.push_back(rx_data);
      end
      tick();
      if (in_rst) begin
        model_reset();
        buf_q.delete();
        if (i == rst_at + 1) check_reset("mid_rst");
      end
    end
    rst = 1'b0;
    rx_data_v = 1'b0;
    frame_release = rel_end;
    #1;
    ok = accept && (buf_q.size() <= DEPTH);
    check("irq", 32'(frame_irq), 32'(ok));
    tick();
    frame_release = 1'b0;
    check("irq_low", 32'(frame_irq), 0);
    if (rel_end && m_cnt > 0) begin
      m_cnt--;
      m_rd ^= 1;
    end
    if (ok) begin
      for (int i = 0; i < buf_q.size(); i++) bank_m[m_wr][i] = buf_q[i];
      m_len[m_wr] = buf_q.size();
      m_wr ^= 1;
      m_cnt++;
    end else if (m_drop < 65535) begin
      m_drop++;
    end
    check_outputs("frm");
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int len;
    model_reset();
    tick(); tick();
    check_reset("init");
    rst = 1'b0;

    // 64 incrementing bytes
    send_frame(64, 1'b1, 1'b0, -1);
    check("t1_len", 32'(frame_len), 64);
    read_check(5);
    check("t1_byte5", 32'(rd_data), 32'h05);
    read_check(63);

    // Three back-to-back frames, only two banks
    do_reset();
    send_frame(10, 1'b0, 1'b0, -1);
    send_frame(20, 1'b0, 1'b0, -1);
    send_frame(30, 1'b0, 1'b0, -1);
    check("t2_drop", 32'(drop_cnt), 1);
    read_check(9);
    release_frame();
    check("t2_bank", 32'(frame_bank), 1);
    check("t2_len", 32'(frame_len), 20);
    read_check(19);

    // Exactly DEPTH bytes, then one byte too many
    do_reset();
    send_frame(1024, 1'b0, 1'b0, -1);
    check("t3_len", 32'(frame_len), 1024);
    read_check(1023);
    read_check(0);
    send_frame(1025, 1'b0, 1'b0, -1);
    check("t3_drop", 32'(drop_cnt), 1);
    release_frame();
    check("t3_empty", 32'(frame_rdy), 0);

    // Release coincides with commit into the other bank
    do_reset();
    send_frame(40, 1'b0, 1'b0, -1);
    send_frame(25, 1'b0, 1'b1, -1);
    check("t4_rdy", 32'(frame_rdy), 1);
    check("t4_bank", 32'(frame_bank), 1);
    check("t4_len", 32'(frame_len), 25);
    read_check(24);

    // Reset after 30 bytes of 100, held 2 cycles
    do_reset();
    send_frame(100, 1'b1, 1'b0, 30);
    check("t5_len", 32'(frame_len), 68);
    check("t5_bank", 32'(frame_bank), 0);
    read_check(0);
    check("t5_first", 32'(rd_data), 32);

    // Release with nothing presented, then drop counter saturation
    do_reset();
    release_frame();
    send_frame(3, 1'b0, 1'b0, -1);
    send_frame(4, 1'b0, 1'b0, -1);
    @(negedge RX_CLK);
    force dut.drop_cnt_q = 16'hFFFD;
    tick();
    release dut.drop_cnt_q;
    m_drop = 16'hFFFD;
    for (int k = 0; k < 4; k++) send_frame(1, 1'b0, 1'b0, -1);
    check("t6_sat", 32'(drop_cnt), 32'hFFFF);

    // Randomized traffic
    do_reset();
    for (int it = 0; it < 40; it++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1020, 1026))
                                        : int'($urandom_range(1, 80));
      send_frame(len, 1'b0, $urandom_range(0, 3) == 0, -1);
      for (int r = 0; r < 3; r++) begin
        if (m_cnt > 0) read_check(int'($urandom_range(0, m_len[m_rd] - 1)));
      end
      if ($urandom_range(0, 1) == 1) release_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
